// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider: restoring shift-subtract,
// one quotient bit per clock, start/busy/done handshake.
module qdiv_seq #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         div_zero
);

    localparam int ITER = N - 1 + Q;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [ITER-1:0] ext_q, ext_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [ITER-1:0] quo_q, quo_d;
    logic [N-2:0]    mag_b_q, mag_b_d;
    logic            sign_q, sign_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    quotient_q, quotient_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            div_zero_q, div_zero_d;

    logic [N:0]      rem_shift;
    logic            rem_ge;
    logic [ITER-1:0] quo_next;
    logic            ovf_hi;
    logic [N-2:0]    mag_res;
    logic            sign_res;

    always_comb begin
        // One restoring step; the shifted remainder gets an extra MSB so the
        // compare against |b| never wraps.
        rem_shift = {rem_q, ext_q[ITER-1]};
        rem_ge    = (rem_shift >= {2'b00, mag_b_q});
        quo_next  = ITER'({quo_q, rem_ge});
        ovf_hi    = |quo_next[ITER-1:N-1];
        mag_res   = ovf_hi ? {(N-1){1'b1}} : quo_next[N-2:0];
        sign_res  = sign_q & (mag_res != '0);

        state_d    = state_q;
        ext_d      = ext_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        mag_b_d    = mag_b_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        quotient_d = quotient_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ovf_d      = 1'b0;
                    div_zero_d = 1'b0;
                    sign_d     = dividend[N-1] ^ divisor[N-1];
                    ext_d      = ITER'(dividend[N-2:0]) << Q;
                    mag_b_d    = divisor[N-2:0];
                    rem_d      = '0;
                    quo_d      = '0;
                    if (divisor[N-2:0] == '0) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                        quotient_d = (dividend[N-2:0] != '0)
                                   ? {dividend[N-1], {(N-1){1'b1}}} : '0;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                        cnt_d   = CW'(ITER);
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_ge ? N'(rem_shift - {2'b00, mag_b_q}) : rem_shift[N-1:0];
                quo_d = quo_next;
                ext_d = ext_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    quotient_d = {sign_res, mag_res};
                    ovf_d      = ovf_hi;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ext_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            mag_b_q    <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            quotient_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ext_q      <= ext_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            mag_b_q    <= mag_b_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            quotient_q <= quotient_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign quotient = quotient_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign div_zero = div_zero_q;

endmodule
